apb_requester: RTL and testbench

//  APB requester (initiator) for the SPI task register bank: converts single-beat
//  cmd_* requests into APB SETUP/ACCESS transfers, honours PREADY wait states and

---
 rtl/apb_requester_pkg.sv | 19 +
 rtl/apb_requester_if.sv | 38 +++
 rtl/apb_requester.sv | 127 ++++++++++++
 tb/tb_apb_requester.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_requester_pkg.sv
// Shared state encoding and default widths for the APB requester.
package apb_requester_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Flat constants so state registers stay plain logic vectors.
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;

  localparam int APB_AWIDTH      = 8;
  localparam int APB_DWIDTH      = 8;
  localparam int APB_TIMEOUT_CYC = 16;

endpackage

// File: rtl/apb_requester_if.sv
// Command/response handshake plus APB bus bundle; master = requester side.
interface apb_requester_if
  import apb_requester_pkg::*;
#(
  parameter int AWIDTH = APB_AWIDTH,
  parameter int DWIDTH = APB_DWIDTH
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_requester.sv
// APB requester: single-beat cmd_* requests -> APB SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int AWIDTH      = APB_AWIDTH,
  parameter int DWIDTH      = APB_DWIDTH,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  apb_requester_if.master bus
);

  logic [1:0]        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [AWIDTH-1:0] r_paddr;
  logic [DWIDTH-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DWIDTH-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic w_done;
  logic w_accept;
  logic w_timeout;

  assign w_done        = (r_state == ST_ACCESS) && bus.PREADY;
  assign bus.cmd_ready = (r_state == ST_IDLE) || w_done;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !bus.PREADY) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYC-th waited ACCESS cycle; PREADY on that cycle wins.
  assign w_timeout = (r_state == ST_ACCESS) && !bus.PREADY &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic [$clog2(TIMEOUT_CYC + 1)-1:0] w_unused_timeout;
  assign w_unused_timeout = '0;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_pwrite <= bus.cmd_write;
        r_paddr  <= bus.cmd_addr;
        r_pwdata <= bus.cmd_wdata;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
          end
        end
        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
            r_rsp_err   <= bus.PSLVERR;
            r_penable   <= 1'b0;
            // Back-to-back accept keeps PSEL high straight into the next SETUP.
            if (w_accept) begin
              r_state <= ST_SETUP;
            end else begin
              r_state <= ST_IDLE;
              r_psel  <= 1'b0;
            end
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: phase checks inline, responses via scoreboard queue.
module tb_apb_requester;

  logic PCLK = 1'b0;
  logic PRESETn;

  always #5 PCLK = ~PCLK;

  apb_requester_if #(.AWIDTH(8), .DWIDTH(8)) bus ();

  apb_requester #(
    .AWIDTH(8),
    .DWIDTH(8),
    .TIMEOUT_CYC(16)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req);
    end
  endtask

  task automatic chk_phase(input string t, input logic s, input logic en);
    chk1({t, "_psel"}, bus.PSEL, s);
    chk1({t, "_penable"}, bus.PENABLE, en);
  endtask

  task automatic drive_cmd(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  task automatic push_exp(input logic [7:0] r, input logic e);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge PCLK) begin
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected none pending");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk8("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk1("rsp_err", bus.rsp_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESETn = 1'b0;
    drive_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    bus.PREADY  = 1'b1;
    bus.PRDATA  = 8'h00;
    bus.PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    chk_phase("rst", 1'b0, 1'b0);
    chk1("rst_pwrite", bus.PWRITE, 1'b0);
    chk8("rst_paddr", bus.PADDR, 8'h00);
    chk8("rst_pwdata", bus.PWDATA, 8'h00);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk8("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    chk1("rst_rsp_err", bus.rsp_err, 1'b0);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    PRESETn = 1'b1;

    // T1: write 0x3C -> 0x05, no wait states
    @(negedge PCLK);
    drive_cmd(1'b1, 1'b1, 8'h05, 8'h3C);
    bus.PREADY = 1'b1;
    push_exp(8'h00, 1'b0);
    #1 chk1("t1_cmd_ready", bus.cmd_ready, 1'b1);
    @(negedge PCLK);
    drive_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    chk_phase("t1_setup", 1'b1, 1'b0);
    chk8("t1_paddr", bus.PADDR, 8'h05);
    chk8("t1_pwdata", bus.PWDATA, 8'h3C);
    chk1("t1_pwrite", bus.PWRITE, 1'b1);
    @(negedge PCLK);
    chk_phase("t1_access", 1'b1, 1'b1);
    chk1("t1_rsp_early", bus.rsp_valid, 1'b0);
    @(negedge PCLK);
    chk1("t1_rsp_valid", bus.rsp_valid, 1'b1);
    chk_phase("t1_idle", 1'b0, 1'b0);
    @(negedge PCLK);
    chk1("t1_rsp_pulse", bus.rsp_valid, 1'b0);
    chk8("t1_paddr_hold", bus.PADDR, 8'h05);

    // T2: read 0x02, three wait states, PRDATA only valid on the ready cycle
    @(negedge PCLK);
    drive_cmd(1'b1, 1'b0, 8'h02, 8'h99);
    bus.PREADY = 1'b0;
    bus.PRDATA = 8'h11;
    push_exp(8'hA5, 1'b0);
    @(negedge PCLK);
    drive_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    chk_phase("t2_setup", 1'b1, 1'b0);
    chk1("t2_pwrite", bus.PWRITE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk_phase("t2_wait", 1'b1, 1'b1);
      chk8("t2_paddr", bus.PADDR, 8'h02);
      chk1("t2_cmd_ready", bus.cmd_ready, 1'b0);
    end
    @(negedge PCLK);
    chk_phase("t2_access4", 1'b1, 1'b1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'hA5;
    @(negedge PCLK);
    chk1("t2_rsp_valid", bus.rsp_valid, 1'b1);
    bus.PRDATA = 8'h00;

    // T3: back-to-back write 0x01 then read 0x02
    @(negedge PCLK);
    drive_cmd(1'b1, 1'b1, 8'h01, 8'h5A);
    bus.PRDATA = 8'h77;
    push_exp(8'h00, 1'b0);
    @(negedge PCLK);
    chk_phase("t3_setup1", 1'b1, 1'b0);
    drive_cmd(1'b1, 1'b0, 8'h02, 8'h00);
    #1 chk1("t3_ready_setup", bus.cmd_ready, 1'b0);
    @(negedge PCLK);
    chk_phase("t3_access1", 1'b1, 1'b1);
    chk8("t3_paddr1", bus.PADDR, 8'h01);
    push_exp(8'h77, 1'b0);
    #1 chk1("t3_ready_access", bus.cmd_ready, 1'b1);
    @(negedge PCLK);
    drive_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    chk_phase("t3_setup2", 1'b1, 1'b0);
    chk8("t3_paddr2", bus.PADDR, 8'h02);
    chk1("t3_pwrite2", bus.PWRITE, 1'b0);
    chk1("t3_rsp1", bus.rsp_valid, 1'b1);
    @(negedge PCLK);
    chk_phase("t3_access2", 1'b1, 1'b1);
    chk1("t3_rsp_gap", bus.rsp_valid, 1'b0);
    @(negedge PCLK);
    chk_phase("t3_idle", 1'b0, 1'b0);
    chk1("t3_rsp2", bus.rsp_valid, 1'b1);

    // T4: read 0x03 completing with PSLVERR
    @(negedge PCLK);
    drive_cmd(1'b1, 1'b0, 8'h03, 8'h00);
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 8'hC3;
    push_exp(8'hC3, 1'b1);
    @(negedge PCLK);
    drive_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge PCLK);
    @(negedge PCLK);
    chk1("t4_rsp_valid", bus.rsp_valid, 1'b1);
    bus.PSLVERR = 1'b0;
    @(negedge PCLK);
    chk1("t4_err_hold", bus.rsp_err, 1'b1);
    chk8("t4_rdata_hold", bus.rsp_rdata, 8'hC3);

    // T5: asynchronous reset in ACCESS, no response afterwards
    @(negedge PCLK);
    drive_cmd(1'b1, 1'b1, 8'h04, 8'h66);
    bus.PREADY = 1'b0;
    @(negedge PCLK);
    drive_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge PCLK);
    chk_phase("t5_access", 1'b1, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk_phase("t5_rst", 1'b0, 1'b0);
    chk1("t5_pwrite", bus.PWRITE, 1'b0);
    chk8("t5_paddr", bus.PADDR, 8'h00);
    chk8("t5_pwdata", bus.PWDATA, 8'h00);
    chk1("t5_rsp_valid", bus.rsp_valid, 1'b0);
    chk8("t5_rsp_rdata", bus.rsp_rdata, 8'h00);
    chk1("t5_rsp_err", bus.rsp_err, 1'b0);
    bus.PREADY = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      chk1("t5_no_rsp", bus.rsp_valid, 1'b0);
    end
    chk1("t5_cmd_ready", bus.cmd_ready, 1'b1);

`ifdef APB_TIMEOUT_EN
    // T6: PREADY stuck low -> abort after 16 ACCESS cycles
    @(negedge PCLK);
    drive_cmd(1'b1, 1'b0, 8'h06, 8'h00);
    bus.PREADY = 1'b0;
    bus.PRDATA = 8'hEE;
    push_exp(8'h00, 1'b1);
    @(negedge PCLK);
    drive_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    chk_phase("t6_setup", 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge PCLK);
      chk_phase("t6_wait", 1'b1, 1'b1);
    end
    @(negedge PCLK);
    chk1("t6_rsp_valid", bus.rsp_valid, 1'b1);
    chk_phase("t6_idle", 1'b0, 1'b0);
    chk1("t6_cmd_ready", bus.cmd_ready, 1'b1);
`else
    // T6: no timeout built in -> 20 wait states then normal completion
    @(negedge PCLK);
    drive_cmd(1'b1, 1'b0, 8'h06, 8'h00);
    bus.PREADY = 1'b0;
    bus.PRDATA = 8'hEE;
    push_exp(8'h5E, 1'b0);
    @(negedge PCLK);
    drive_cmd(1'b0, 1'b0, 8'h00, 8'h00);
    chk_phase("t6_setup", 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      chk_phase("t6_wait", 1'b1, 1'b1);
      chk1("t6_no_rsp", bus.rsp_valid, 1'b0);
    end
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h5E;
    @(negedge PCLK);
    chk1("t6_rsp_valid", bus.rsp_valid, 1'b1);
    chk_phase("t6_idle", 1'b0, 1'b0);
`endif

    repeat (3) @(negedge PCLK);
    chk1("scoreboard_empty", exp_q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
